pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and flush controller for the in-order MIPS pipeline core.
- Tracks in-flight destination-register tags for every stage after ID (EX, MEM, …, WB) in its own tag pipeline.
- From those tags it produces ID-stage stall, branch flush and per-operand forwarding selects.
- Successor to the fixed 5-stage, hazard-free pipeline: adds configurable depth, load-use interlock, optional forwarding and configurable branch-resolve stage.

Parameters:
REG_ADDR_W, 5, register-address width
DEPTH, 3, number of tracked stages after ID (index 0 = EX … DEPTH-1 = WB); legal 2..8
FWD_EN, 1, 1 = forwarding paths exist; 0 = interlock-only
LOAD_READY, 1, lowest stage index at which load data is forwardable (1 = MEM output)
BR_STAGE, 1, stage index that asserts i_br_taken (1 = MEM); legal 0..DEPTH-2
SEL_W, $clog2(DEPTH+1), forwarding-select width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_id_valid  in  1  ID holds a real instruction
i_id_rs  in  REG_ADDR_W  source 1 address
i_id_rt  in  REG_ADDR_W  source 2 address
i_id_rs_used  in  1  source 1 is read
i_id_rt_used  in  1  source 2 is read
i_id_wen  in  1  ID instruction writes a register
i_id_rd  in  REG_ADDR_W  final destination address (post rt/rd mux)
i_id_is_load  in  1  ID instruction is a load
i_br_taken  in  1  branch/jump resolved taken at stage BR_STAGE
o_stall  out  1  hold PC and IF/ID; bubble into EX
o_flush  out  1  squash IF/ID and every stage register younger than BR_STAGE
o_fwd_rs_sel  out  SEL_W  0 = regfile, k = result of stage k-1
o_fwd_rt_sel  out  SEL_W  as above for rt
o_stage_valid  out  DEPTH  valid bit of each tag entry
o_stall_cnt  out  16  saturating count of stall cycles

Behaviour:
- Reset (async, i_rst_n=0): all tag entries invalid; o_stage_valid=0; o_stall_cnt=0. Combinational outputs settle to 0.
- Tag entry fields: valid, wen, rd, is_load. Entries with rd==0 or wen==0 never match.
- Match search, per used source s≠0: pick the youngest matching entry k, i.e. the smallest index with valid&wen&rd==s.
- FWD_EN=1:
  - Match is a load with k<LOAD_READY -> stall.
  - Otherwise sel = k+1.
  - No match -> sel = 0.
- FWD_EN=0:
  - Match with k<DEPTH-1 -> stall.
  - Match at DEPTH-1 -> sel = DEPTH (WB bypass).
  - No match -> 0.
- o_stall = i_id_valid & (any source stalls) & ~i_br_taken. Combinational, same cycle.
- o_flush = i_br_taken, combinational. Flush overrides stall.
- Sels are don't-care while o_stall=1, but are driven deterministically per the rules above.
- Posedge update, new[j] = old[j-1] for j≥1, last entry retires:
  - Flush: new[0..BR_STAGE] invalid; new[j>BR_STAGE] = old[j-1]. The branch moves to BR_STAGE+1.
  - Stall (no flush): new[0] = bubble.
  - Otherwise: new[0] = ID fields, valid = i_id_valid.
- o_stall_cnt increments on every cycle with o_stall=1 and holds at 0xFFFF.
- Stall releases automatically once the load reaches LOAD_READY. Maximum stall length is LOAD_READY cycles with FWD_EN=1, or DEPTH-1 cycles with FWD_EN=0.
- If reset asserts mid-stall or mid-flush, all state clears immediately; no pending flush survives.

Decomposition:
- Shared package pipe_pkg holds:
  - the tag struct {valid, wen, rd, is_load};
  - the bubble constant;
  - the select encoding constants (SEL_RF=0).
- One sub-module, hazard_tag_pipe: the DEPTH-entry tag shift register with stall/flush insertion. Match/select logic stays in the top.

Test Plan:
- Defaults. add r3 enters EX; next ID uses rs=r3 -> o_stall=0, o_fwd_rs_sel=1. One cycle later (tag at MEM), reader -> sel=2.
- lw r5 in EX, ID reads rt=r5 -> o_stall=1 for exactly 1 cycle, o_stage_valid=3'b010 after the bubble; next cycle o_stall=0, o_fwd_rt_sel=2. o_stall_cnt=1.
- FWD_EN=0, add r4 just issued, ID reads r4 -> o_stall high 2 cycles, then sel=3 (WB). o_stall_cnt=2.
- i_br_taken=1 with tags EX,MEM,WB valid and a stalling ID -> o_flush=1, o_stall=0. Next cycle o_stage_valid=3'b100 (branch in WB only).
- Reader of r0 with an r0-writer in EX -> no stall, sel=0. Two writers of r7 in EX and MEM -> sel=1 (youngest).
- Assert i_rst_n=0 mid-stall -> o_stall_cnt=0 and o_stage_valid=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the per-stage destination tag, the bubble value inserted on stall or
// flush, and the forwarding-select encoding.
package pipe_pkg;

  // Widest register address a tag can hold; narrower addresses are zero-extended.
  localparam int unsigned RD_MAX_W = 8;

  // Forwarding select value meaning "read the register file".
  localparam int unsigned SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic                wen;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '{valid: 1'b0, wen: 1'b0, rd: '0, is_load: 1'b0};

endpackage

// File: rtl/hazard_tag_pipe.sv
// Destination-tag shift register for the stages after ID.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_stall        : insert a bubble instead of the ID tag
//   i_flush        : squash every entry up to and including BR_STAGE
//   i_id_tag       : tag of the instruction currently in ID
//   o_tags         : registered entries, index 0 = EX ... DEPTH-1 = WB
module hazard_tag_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned BR_STAGE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_flush,
  input  tag_t             i_id_tag,
  output tag_t [DEPTH-1:0] o_tags
);

  tag_t [DEPTH-1:0] tags_q;
  tag_t [DEPTH-1:0] tags_d;

  // Advance one stage; flush kills the branch's younger stages, stall injects a bubble.
  always_comb begin
    tags_d = tags_q;
    for (int unsigned j = 1; j < DEPTH; j++) begin
      tags_d[j] = tags_q[j-1];
    end
    if (i_flush) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j <= BR_STAGE) begin
          tags_d[j] = TAG_BUBBLE;
        end
      end
    end else if (i_stall) begin
      tags_d[0] = TAG_BUBBLE;
    end else begin
      tags_d[0] = i_id_tag;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tags_q <= {DEPTH{TAG_BUBBLE}};
    end else begin
      tags_q <= tags_d;
    end
  end

  assign o_tags = tags_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flush controller for the in-order pipeline.
// Tracks in-flight destination tags and derives the ID-stage stall, the
// branch flush and per-operand forwarding selects.
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_id_*                  : decoded fields of the instruction in ID
//   i_br_taken              : branch resolved taken at stage BR_STAGE
//   o_stall, o_flush        : same-cycle stall / flush (combinational)
//   o_fwd_rs_sel/rt_sel     : 0 = regfile, k = result of stage k-1
//   o_stage_valid           : valid bit of each tracked stage
//   o_stall_cnt             : saturating count of stall cycles
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DEPTH      = 3,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned LOAD_READY = 1,
  parameter int unsigned BR_STAGE   = 1,
  parameter int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_rs_used,
  input  logic                  i_id_rt_used,
  input  logic                  i_id_wen,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_is_load,
  input  logic                  i_br_taken,
  output logic                  o_stall,
  output logic                  o_flush,
  output logic [SEL_W-1:0]      o_fwd_rs_sel,
  output logic [SEL_W-1:0]      o_fwd_rt_sel,
  output logic [DEPTH-1:0]      o_stage_valid,
  output logic [15:0]           o_stall_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic             stall;
    logic [SEL_W-1:0] sel;
  } src_res_t;

  // Youngest matching writer decides: forward from it, or stall until it can.
  function automatic src_res_t resolve(input logic [REG_ADDR_W-1:0] src,
                                       input logic                  used,
                                       input tag_t [DEPTH-1:0]      tags);
    src_res_t    res;
    logic        found;
    logic        is_ld;
    int unsigned k;
    res.stall = 1'b0;
    res.sel   = SEL_W'(SEL_RF);
    found     = 1'b0;
    is_ld     = 1'b0;
    k         = 0;
    if (used && (src != '0)) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (!found && tags[j].valid && tags[j].wen && (tags[j].rd != '0) &&
            (tags[j].rd == RD_MAX_W'(src))) begin
          found = 1'b1;
          k     = j;
          is_ld = tags[j].is_load;
        end
      end
      if (found) begin
        if (FWD_EN) begin
          if (is_ld && (k < LOAD_READY)) res.stall = 1'b1;
          else                           res.sel   = SEL_W'(k + 1);
        end else begin
          if (k < DEPTH - 1) res.stall = 1'b1;
          else               res.sel   = SEL_W'(DEPTH);
        end
      end
    end
    return res;
  endfunction

  tag_t             id_tag_c;
  tag_t [DEPTH-1:0] tags;
  src_res_t         rs_res_c;
  src_res_t         rt_res_c;
  logic             stall_c;
  logic [15:0]      stall_cnt_q;
  logic [15:0]      stall_cnt_d;

  // Tag of the instruction in ID; an invalid slot enters the pipe as a non-matching entry.
  always_comb begin
    id_tag_c         = TAG_BUBBLE;
    id_tag_c.valid   = i_id_valid;
    id_tag_c.wen     = i_id_wen;
    id_tag_c.rd      = RD_MAX_W'(i_id_rd);
    id_tag_c.is_load = i_id_is_load;
  end

  hazard_tag_pipe #(
    .DEPTH    (DEPTH),
    .BR_STAGE (BR_STAGE)
  ) u_tag_pipe (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_stall  (stall_c),
    .i_flush  (i_br_taken),
    .i_id_tag (id_tag_c),
    .o_tags   (tags)
  );

  // Flush wins over stall: the stalled ID instruction is squashed anyway.
  always_comb begin
    rs_res_c = resolve(i_id_rs, i_id_rs_used, tags);
    rt_res_c = resolve(i_id_rt, i_id_rt_used, tags);
    stall_c  = i_id_valid & (rs_res_c.stall | rt_res_c.stall) & ~i_br_taken;
  end

  always_comb begin
    o_stage_valid = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      o_stage_valid[j] = tags[j].valid;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall      = stall_c;
  assign o_flush      = i_br_taken;
  assign o_fwd_rs_sel = rs_res_c.sel;
  assign o_fwd_rt_sel = rt_res_c.sel;
  assign o_stall_cnt  = stall_cnt_q;

endmodule
